mitm_byte_substitutor: RTL and testbench

Man-in-the-middle logic that sits on the logic side of the bus interface block, consuming its receive status/data and driving its fake-send controls. For each direction (if0→if1 and if1→if0) it buffers received words, optionally substitutes one configured word value with another, and re-transmits them on the opposite interface. Each direction switches cleanly between electrical passthrough and store-and-forward.

---
 rtl/mitm_pkg.sv | 22 ++
 rtl/mitm_channel.sv | 196 +++++++++++++++++++
 rtl/mitm_byte_substitutor.sv | 87 ++++++++
 tb/tb_mitm_byte_substitutor.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mitm_pkg.sv
// Shared definitions for the man-in-the-middle byte substitutor:
// send-FSM state encoding, substitution-counter width and a saturating
// increment helper used when MITM_SUBST_COUNT_EN is defined.
package mitm_pkg;

  // Width of the optional per-direction substitution counters.
  localparam int unsigned SUBST_CNT_W = 16;

  // Per-channel send FSM: hand a word to the transmitter, wait for it to go
  // busy, then wait for it to become idle again.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } send_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [SUBST_CNT_W-1:0] sat_inc(input logic [SUBST_CNT_W-1:0] v);
    return (&v) ? v : v + SUBST_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mitm_channel.sv
// One direction of the man-in-the-middle path: receive strobes are pushed
// (optionally substituted) into a small FIFO while the fake transmitter is
// selected, and a three-state FSM re-sends them one at a time on the
// opposite interface. The select flop only moves while the channel is
// quiescent, so a hand-over never cuts a word in half.
// Optional feature: define MITM_SUBST_COUNT_EN to add a saturating counter
// of pushes whose word was substituted.
module mitm_channel
  import mitm_pkg::*;
#(
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 4   // power of two, >= 2
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     cfg_subst_en,
  input  logic [NUM_DATA_BITS-1:0] cfg_match,
  input  logic [NUM_DATA_BITS-1:0] cfg_replace,
  input  logic                     recv_strobe,
  input  logic [NUM_DATA_BITS-1:0] recv_data,
  input  logic                     send_ready,
  output logic                     send_select,
  output logic                     send_start,
  output logic [NUM_DATA_BITS-1:0] send_data,
  output logic                     ovf
`ifdef MITM_SUBST_COUNT_EN
  ,
  output logic [SUBST_CNT_W-1:0]   subst_cnt
`endif
);

  localparam int unsigned    PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Word storage and its bookkeeping.
  logic [NUM_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]           count_q,  count_d;

  // Registered outputs and FSM state.
  logic                     select_q, select_d;
  logic                     start_q,  start_d;
  logic [NUM_DATA_BITS-1:0] data_q,   data_d;
  logic                     ovf_q,    ovf_d;
  send_state_e              state_q,  state_d;

`ifdef MITM_SUBST_COUNT_EN
  logic [SUBST_CNT_W-1:0]   cnt_q, cnt_d;
`endif

  // Decoded conditions for this cycle.
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     quiescent;
  logic                     subst_hit;
  logic [NUM_DATA_BITS-1:0] push_word;
  logic                     push_req;
  logic                     push;
  logic                     pop;
  logic                     drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // Nothing buffered, nothing in flight and the transmitter idle: the only
  // moment the output line may change hands.
  assign quiescent  = fifo_empty && (state_q == ST_IDLE) && send_ready;

  // Substitution is decided on the word as it arrives.
  assign subst_hit  = cfg_subst_en && (recv_data == cfg_match);
  assign push_word  = subst_hit ? cfg_replace : recv_data;

  // While deselected the word already crossed electrically, so ignore it.
  assign push_req   = select_q && recv_strobe;

  // The head leaves the FIFO in the same cycle it is loaded for sending.
  assign pop        = (state_q == ST_IDLE) && !fifo_empty && send_ready && select_q;

  // A full FIFO still accepts a word if the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // Next-state logic: FIFO bookkeeping, select hand-over, send FSM and flags.
  always_comb begin
    // NOTE: every signal gets its default first so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    select_d = select_q;
    state_d  = state_q;
    start_d  = 1'b0;
    data_d   = data_q;
    ovf_d    = ovf_q | drop;

    if (quiescent) begin
      select_d = enable;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          data_d  = mem_q[rd_ptr_q];
          start_d = 1'b1;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!send_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (send_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef MITM_SUBST_COUNT_EN
  // Count accepted pushes that carried a substituted word.
  always_comb begin
    cnt_d = cnt_q;
    if (push && subst_hit) begin
      cnt_d = sat_inc(cnt_q);
    end
  end
`endif

  // Control and output registers; reset empties the FIFO and parks the FSM.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      select_q <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
`ifdef MITM_SUBST_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      select_q <= select_d;
      start_q  <= start_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
`ifdef MITM_SUBST_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // FIFO storage write port.
  always_ff @(posedge sys_clk) begin
    // NOTE: the storage array is not reset; clearing the pointers already discards its contents.
    if (push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign send_select = select_q;
  assign send_start  = start_q;
  assign send_data   = data_q;
  assign ovf         = ovf_q;
`ifdef MITM_SUBST_COUNT_EN
  assign subst_cnt   = cnt_q;
`endif

endmodule

// File: rtl/mitm_byte_substitutor.sv
// Man-in-the-middle byte substitutor: two independent store-and-forward
// channels between bus interfaces if0 and if1. Channel 0to1 buffers words
// received on if0 and re-sends them on if1; channel 1to0 is the mirror.
// Optional feature: define MITM_SUBST_COUNT_EN to add the 16-bit
// subst_cnt_0to1 / subst_cnt_1to0 outputs.
module mitm_byte_substitutor
  import mitm_pkg::*;
#(
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     cfg_subst_en,
  input  logic [NUM_DATA_BITS-1:0] cfg_match,
  input  logic [NUM_DATA_BITS-1:0] cfg_replace,
  input  logic                     if0_recv_new_data_ready,
  input  logic                     if1_recv_new_data_ready,
  input  logic [NUM_DATA_BITS-1:0] real_if0_recv_data,
  input  logic [NUM_DATA_BITS-1:0] real_if1_recv_data,
  input  logic                     if0_send_ready,
  input  logic                     if1_send_ready,
  output logic                     fake_if0_send_select,
  output logic                     fake_if1_send_select,
  output logic                     fake_if0_send_start,
  output logic                     fake_if1_send_start,
  output logic [NUM_DATA_BITS-1:0] fake_if0_send_data,
  output logic [NUM_DATA_BITS-1:0] fake_if1_send_data,
  output logic                     ovf_0to1,
  output logic                     ovf_1to0
`ifdef MITM_SUBST_COUNT_EN
  ,
  output logic [SUBST_CNT_W-1:0]   subst_cnt_0to1,
  output logic [SUBST_CNT_W-1:0]   subst_cnt_1to0
`endif
);

  // if0 receive -> if1 fake transmit.
  mitm_channel #(
    .NUM_DATA_BITS (NUM_DATA_BITS),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) u_ch_0to1 (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_subst_en (cfg_subst_en),
    .cfg_match    (cfg_match),
    .cfg_replace  (cfg_replace),
    .recv_strobe  (if0_recv_new_data_ready),
    .recv_data    (real_if0_recv_data),
    .send_ready   (if1_send_ready),
    .send_select  (fake_if1_send_select),
    .send_start   (fake_if1_send_start),
    .send_data    (fake_if1_send_data),
    .ovf          (ovf_0to1)
`ifdef MITM_SUBST_COUNT_EN
    ,
    .subst_cnt    (subst_cnt_0to1)
`endif
  );

  // if1 receive -> if0 fake transmit.
  mitm_channel #(
    .NUM_DATA_BITS (NUM_DATA_BITS),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) u_ch_1to0 (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_subst_en (cfg_subst_en),
    .cfg_match    (cfg_match),
    .cfg_replace  (cfg_replace),
    .recv_strobe  (if1_recv_new_data_ready),
    .recv_data    (real_if1_recv_data),
    .send_ready   (if0_send_ready),
    .send_select  (fake_if0_send_select),
    .send_start   (fake_if0_send_start),
    .send_data    (fake_if0_send_data),
    .ovf          (ovf_1to0)
`ifdef MITM_SUBST_COUNT_EN
    ,
    .subst_cnt    (subst_cnt_1to0)
`endif
  );

endmodule

// File: tb/tb_mitm_byte_substitutor.sv
// Self-checking bench for mitm_byte_substitutor. Expected words are kept in
// per-direction queues filled at strobe time from the substitution rule and
// drained by a monitor that watches the fake send strobes. A simple
// transmitter model answers send_start by dropping send_ready for a random
// number of cycles. Outputs are sampled on the falling clock edge.
module tb_mitm_byte_substitutor;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         sys_clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         cfg_subst_en;
  logic [W-1:0] cfg_match;
  logic [W-1:0] cfg_replace;
  logic         if0_recv_new_data_ready;
  logic         if1_recv_new_data_ready;
  logic [W-1:0] real_if0_recv_data;
  logic [W-1:0] real_if1_recv_data;
  logic         if0_send_ready;
  logic         if1_send_ready;
  logic         fake_if0_send_select;
  logic         fake_if1_send_select;
  logic         fake_if0_send_start;
  logic         fake_if1_send_start;
  logic [W-1:0] fake_if0_send_data;
  logic [W-1:0] fake_if1_send_data;
  logic         ovf_0to1;
  logic         ovf_1to0;
`ifdef MITM_SUBST_COUNT_EN
  logic [15:0]  subst_cnt_0to1;
  logic [15:0]  subst_cnt_1to0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  logic [W-1:0] exp_q01[$];
  logic [W-1:0] exp_q10[$];
  int  exp_cnt01 = 0;
  int  exp_cnt10 = 0;
  bit  auto_rdy0 = 1'b0;
  bit  auto_rdy1 = 1'b0;
  bit  prev_start0 = 1'b0;
  bit  prev_start1 = 1'b0;

  mitm_byte_substitutor #(
    .NUM_DATA_BITS (W),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .sys_clk                 (sys_clk),
    .rst                     (rst),
    .enable                  (enable),
    .cfg_subst_en            (cfg_subst_en),
    .cfg_match               (cfg_match),
    .cfg_replace             (cfg_replace),
    .if0_recv_new_data_ready (if0_recv_new_data_ready),
    .if1_recv_new_data_ready (if1_recv_new_data_ready),
    .real_if0_recv_data      (real_if0_recv_data),
    .real_if1_recv_data      (real_if1_recv_data),
    .if0_send_ready          (if0_send_ready),
    .if1_send_ready          (if1_send_ready),
    .fake_if0_send_select    (fake_if0_send_select),
    .fake_if1_send_select    (fake_if1_send_select),
    .fake_if0_send_start     (fake_if0_send_start),
    .fake_if1_send_start     (fake_if1_send_start),
    .fake_if0_send_data      (fake_if0_send_data),
    .fake_if1_send_data      (fake_if1_send_data),
    .ovf_0to1                (ovf_0to1),
    .ovf_1to0                (ovf_1to0)
`ifdef MITM_SUBST_COUNT_EN
    ,
    .subst_cnt_0to1          (subst_cnt_0to1),
    .subst_cnt_1to0          (subst_cnt_1to0)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Reference substitution rule, evaluated with the configuration at push time.
  function automatic logic [W-1:0] model_word(input logic [W-1:0] d);
    if (cfg_subst_en && d == cfg_match) return cfg_replace;
    return d;
  endfunction

  function automatic logic [W-1:0] pick_data();
    if ($urandom_range(0, 3) == 0) return cfg_match;
    return W'($urandom);
  endfunction

  // Advance to the next falling edge and end any one-cycle receive strobes.
  task automatic step();
    @(negedge sys_clk);
    if0_recv_new_data_ready = 1'b0;
    if1_recv_new_data_ready = 1'b0;
  endtask

  task automatic strobe0(input logic [W-1:0] d, input bit accepted);
    if0_recv_new_data_ready = 1'b1;
    real_if0_recv_data      = d;
    if (accepted) begin
      exp_q01.push_back(model_word(d));
      if (cfg_subst_en && d == cfg_match) exp_cnt01++;
    end
  endtask

  task automatic strobe1(input logic [W-1:0] d, input bit accepted);
    if1_recv_new_data_ready = 1'b1;
    real_if1_recv_data      = d;
    if (accepted) begin
      exp_q10.push_back(model_word(d));
      if (cfg_subst_en && d == cfg_match) exp_cnt10++;
    end
  endtask

  // Wait (bounded) until every expected word has been sent.
  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q01.size() != 0 || exp_q10.size() != 0) && k < 300) begin
      step();
      k++;
    end
    check(tag, 32'(exp_q01.size() + exp_q10.size()), 32'd0);
    repeat (6) step();
  endtask

  // Wait (bounded) for the next send strobe towards if1.
  task automatic wait_start1(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = fake_if1_send_start;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel0"},  32'(fake_if0_send_select), 32'd0);
    check({tag, "_sel1"},  32'(fake_if1_send_select), 32'd0);
    check({tag, "_start0"}, 32'(fake_if0_send_start), 32'd0);
    check({tag, "_start1"}, 32'(fake_if1_send_start), 32'd0);
    check({tag, "_data0"}, 32'(fake_if0_send_data), 32'd0);
    check({tag, "_data1"}, 32'(fake_if1_send_data), 32'd0);
    check({tag, "_ovf01"}, 32'(ovf_0to1), 32'd0);
    check({tag, "_ovf10"}, 32'(ovf_1to0), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    exp_q01.delete();
    exp_q10.delete();
    exp_cnt01 = 0;
    exp_cnt10 = 0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // Monitor: every send strobe must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        if (fake_if1_send_start) begin
          check("sel01_at_start", 32'(fake_if1_send_select), 32'd1);
          check("start01_pulse", 32'(prev_start1), 32'd0);
          if (exp_q01.size() > 0) check("data01", 32'(fake_if1_send_data), 32'(exp_q01.pop_front()));
          else check("start01_expected", 32'(exp_q01.size()), 32'd1);
        end
        if (fake_if0_send_start) begin
          check("sel10_at_start", 32'(fake_if0_send_select), 32'd1);
          check("start10_pulse", 32'(prev_start0), 32'd0);
          if (exp_q10.size() > 0) check("data10", 32'(fake_if0_send_data), 32'(exp_q10.pop_front()));
          else check("start10_expected", 32'(exp_q10.size()), 32'd1);
        end
      end
      prev_start1 = fake_if1_send_start && rst;
      prev_start0 = fake_if0_send_start && rst;
    end
  end

  // Transmitter models: go busy on a start, return idle after 1..3 cycles.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (auto_rdy1 && rst && fake_if1_send_start) begin
        if1_send_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge sys_clk);
        if1_send_ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (auto_rdy0 && rst && fake_if0_send_start) begin
        if0_send_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge sys_clk);
        if0_send_ready = 1'b1;
      end
    end
  end

  initial begin
    logic [W-1:0] cnt_seq [5];

    rst                     = 1'b0;
    enable                  = 1'b0;
    cfg_subst_en            = 1'b0;
    cfg_match               = '0;
    cfg_replace             = '0;
    if0_recv_new_data_ready = 1'b0;
    if1_recv_new_data_ready = 1'b0;
    real_if0_recv_data      = '0;
    real_if1_recv_data      = '0;
    if0_send_ready          = 1'b1;
    if1_send_ready          = 1'b1;

    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    // Passthrough: strobes while deselected are ignored.
    strobe0(8'h41, 1'b0);
    strobe1(8'h41, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("pt_sel01", 32'(fake_if1_send_select), 32'd0);
      check("pt_start01", 32'(fake_if1_send_start), 32'd0);
    end

    // Forward with substitution, manual transmitter handshake on if1.
    cfg_subst_en = 1'b1;
    cfg_match    = 8'h41;
    cfg_replace  = 8'h5A;
    enable       = 1'b1;
    step();
    check("sel01_rise", 32'(fake_if1_send_select), 32'd1);
    check("sel10_rise", 32'(fake_if0_send_select), 32'd1);
    strobe0(8'h41, 1'b1);
    step();
    check("lat_no_start_n1", 32'(fake_if1_send_start), 32'd0);
    strobe0(8'h42, 1'b1);
    step();
    check("lat_start_n2", 32'(fake_if1_send_start), 32'd1);
    check("lat_data_n2", 32'(fake_if1_send_data), 32'h5A);
    if1_send_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_no_start", 32'(fake_if1_send_start), 32'd0);
      check("busy_data_hold", 32'(fake_if1_send_data), 32'h5A);
    end
    if1_send_ready = 1'b1;
    check("no_start_on_ready_cycle", 32'(fake_if1_send_start), 32'd0);
    wait_start1("second_start");
    check("second_data", 32'(fake_if1_send_data), 32'h42);
    if1_send_ready = 1'b0;
    step();
    step();
    if1_send_ready = 1'b1;
    drain("fwd_drain");

    // Overflow: transmitter busy, five words into a four-deep FIFO.
    cfg_subst_en   = 1'b0;
    if1_send_ready = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      strobe0(W'(i), 1'b1);
      step();
    end
    check("ovf_before_5th", 32'(ovf_0to1), 32'd0);
    strobe0(8'h05, 1'b0);
    step();
    check("ovf01_set", 32'(ovf_0to1), 32'd1);
    check("ovf10_clear", 32'(ovf_1to0), 32'd0);
    auto_rdy1      = 1'b1;
    if1_send_ready = 1'b1;
    drain("ovf_drain");
    check("ovf01_sticky", 32'(ovf_0to1), 32'd1);
    auto_rdy1 = 1'b0;
    step();

    // Disable with two words queued: both go out, then select drops.
    if1_send_ready = 1'b0;
    step();
    strobe0(8'h11, 1'b1);
    step();
    strobe0(8'h22, 1'b1);
    step();
    enable = 1'b0;
    step();
    step();
    check("dis_sel_held", 32'(fake_if1_send_select), 32'd1);
    if1_send_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      wait_start1("dis_start");
      if1_send_ready = 1'b0;
      step();
      step();
      if1_send_ready = 1'b1;
      check("dis_sel_mid", 32'(fake_if1_send_select), 32'd1);
    end
    step();
    step();
    check("dis_sel_fell", 32'(fake_if1_send_select), 32'd0);
    check("dis_queue_empty", 32'(exp_q01.size()), 32'd0);

    // Reset while the transmitter is busy with a word and one more is queued.
    enable = 1'b1;
    step();
    step();
    check("rst_sel_up", 32'(fake_if1_send_select), 32'd1);
    strobe0(8'h33, 1'b1);
    step();
    strobe0(8'h44, 1'b1);
    step();
    check("rst_start", 32'(fake_if1_send_start), 32'd1);
    if1_send_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q01.delete();
    exp_q10.delete();
    exp_cnt01 = 0;
    exp_cnt10 = 0;
    step();
    check_reset_outputs("midrst");
    rst            = 1'b1;
    if1_send_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rst_fifo_empty", 32'(fake_if1_send_start), 32'd0);
    end

    // Randomized traffic on both directions with random transmitter delays.
    auto_rdy0 = 1'b1;
    auto_rdy1 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cfg_subst_en = (r == 0);
      cfg_match    = W'($urandom);
      cfg_replace  = W'($urandom);
      for (int c = 0; c < 500; c++) begin
        if (exp_q01.size() < DEPTH && $urandom_range(0, 2) == 0) strobe0(pick_data(), 1'b1);
        if (exp_q10.size() < DEPTH && $urandom_range(0, 2) == 0) strobe1(pick_data(), 1'b1);
        step();
      end
      drain("rand_drain");
    end
    check("rand_ovf01", 32'(ovf_0to1), 32'd0);
    check("rand_ovf10", 32'(ovf_1to0), 32'd0);
`ifdef MITM_SUBST_COUNT_EN
    check("rand_cnt01", 32'(subst_cnt_0to1), 32'(exp_cnt01));
    check("rand_cnt10", 32'(subst_cnt_1to0), 32'(exp_cnt10));

    // Counters: three matching and two non-matching pushes on if0.
    apply_reset();
    check("cnt01_reset", 32'(subst_cnt_0to1), 32'd0);
    cfg_subst_en = 1'b1;
    cfg_match    = 8'h41;
    cfg_replace  = 8'h5A;
    step();
    step();
    cnt_seq = '{8'h41, 8'h10, 8'h41, 8'h20, 8'h41};
    for (int i = 0; i < 5; i++) begin
      strobe0(cnt_seq[i], 1'b1);
      step();
      drain("cnt_drain");
    end
    check("cnt01_three", 32'(subst_cnt_0to1), 32'd3);
    check("cnt10_zero", 32'(subst_cnt_1to0), 32'd0);
`else
    cnt_seq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    if (cnt_seq[0] != 8'h00) $display("unexpected init");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
